wired_bus_resolver: RTL

Synthesizable, clocked successor to our wired-net experiments. It resolves `N_DRV` enable-qualified drivers of a `W`-bit shared bus under a run-time selectable mode: wired-OR, wired-AND, or single-driver tri-state with contention detection. It adds a bus keeper with timed decay to an idle value, plus saturating contention statistics. It sits between multi-master peripherals and a shared status/data bus, replacing behavioural `wor`/`wand` nets in synthesizable logic.

---
 rtl/wired_bus_resolver_pkg.sv | 23 ++
 rtl/wired_bus_resolver_if.sv | 30 +++
 rtl/wired_bus_reduce.sv | 37 +++
 rtl/wired_bus_resolver.sv | 119 +++++++++++
 4 files changed

// File: rtl/wired_bus_resolver_pkg.sv
// Shared types for the wired bus resolver: resolution modes, keeper states,
// and the per-mode idle level.
package wired_bus_pkg;

  typedef enum logic [1:0] {
    MODE_WOR  = 2'd0,
    MODE_WAND = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    KS_DRIVEN = 2'd0,
    KS_HOLD   = 2'd1,
    KS_IDLE   = 2'd2
  } keep_state_e;

  // Idle bus level for a mode; callers replicate it across the bus width.
  function automatic logic idle_level(mode_e m);
    return (m == MODE_WAND);
  endfunction

endpackage

// File: rtl/wired_bus_resolver_if.sv
// Driver-side inputs and resolved-bus outputs of the wired bus resolver.
interface wired_bus_resolver_if #(
  parameter int N_DRV = 4,
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  import wired_bus_pkg::*;

  mode_e                mode;
  logic [N_DRV-1:0]     drv_en;
  logic [N_DRV*W-1:0]   drv_data;
  logic                 err_clr;
  logic [W-1:0]         bus_q;
  logic                 bus_valid;
  logic                 idle;
  logic                 contention;
  logic                 err_sticky;
  logic [CNT_W-1:0]     contention_cnt;

  modport master (
    output mode, drv_en, drv_data, err_clr,
    input  bus_q, bus_valid, idle, contention, err_sticky, contention_cnt
  );

  modport slave (
    input  mode, drv_en, drv_data, err_clr,
    output bus_q, bus_valid, idle, contention, err_sticky, contention_cnt
  );

endinterface

// File: rtl/wired_bus_reduce.sv
// Combinational resolution of N_DRV enable-qualified drivers under the
// selected mode; disabled drivers are masked out before any reduction.
module wired_bus_reduce
  import wired_bus_pkg::*;
#(
  parameter int N_DRV = 4,
  parameter int W     = 8
) (
  input  mode_e              mode,
  input  logic [N_DRV-1:0]   drv_en,
  input  logic [N_DRV*W-1:0] drv_data,
  output logic [W-1:0]       value,
  output logic               any_en,
  output logic               conflict
);

  logic [W-1:0] or_v;
  logic [W-1:0] and_v;

  // NOTE: combinational logic uses blocking '=' and gives every output a
  // default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    or_v   = '0;
    and_v  = '1;
    any_en = |drv_en;
    for (int i = 0; i < N_DRV; i++) begin
      if (drv_en[i]) begin
        or_v  = or_v  | drv_data[i*W +: W];
        and_v = and_v & drv_data[i*W +: W];
      end
    end
    // Enabled drivers agree on every bit exactly when their OR equals their AND.
    conflict = (mode == MODE_TRI) && any_en && (or_v != and_v);
    value    = (mode == MODE_WAND) ? and_v : or_v;
  end

endmodule

// File: rtl/wired_bus_resolver.sv
// Registered wired-bus resolver: mode-selected reduction, keeper with timed
// decay to the idle level, and sticky/saturating contention statistics.
module wired_bus_resolver
  import wired_bus_pkg::*;
#(
  parameter int N_DRV       = 4,
  parameter int W           = 8,
  parameter int KEEP_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst,
  wired_bus_resolver_if.slave bus
);

  localparam int HW = (KEEP_CYCLES > 0) ? $clog2(KEEP_CYCLES + 1) : 1;
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(KEEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  keep_state_e      state;
  logic [HW-1:0]    hold_cnt;
  logic [W-1:0]     bus_q_r;
  logic             valid_r;
  logic             idle_r;
  logic             cont_r;
  logic             sticky_r;
  logic [CNT_W-1:0] cnt_r;

  logic [W-1:0]     value;
  logic             any_en;
  logic             conflict;
  logic [W-1:0]     idle_val;
  logic             err_event;
  logic [CNT_W-1:0] cnt_base;

  wired_bus_reduce #(.N_DRV(N_DRV), .W(W)) u_reduce (
    .mode     (bus.mode),
    .drv_en   (bus.drv_en),
    .drv_data (bus.drv_data),
    .value    (value),
    .any_en   (any_en),
    .conflict (conflict)
  );

  // A clear and a new event in the same cycle: the clear applies first.
  always_comb begin
    idle_val  = {W{idle_level(bus.mode)}};
    err_event = conflict || (bus.mode == MODE_RSVD);
    cnt_base  = bus.err_clr ? '0 : cnt_r;
  end

  // NOTE: sequential state is written with non-blocking '<=' only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= KS_IDLE;
      hold_cnt <= '0;
      bus_q_r  <= '0;
      valid_r  <= 1'b0;
      idle_r   <= 1'b1;
      cont_r   <= 1'b0;
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      cont_r <= conflict;

      if (err_event)        sticky_r <= 1'b1;
      else if (bus.err_clr) sticky_r <= 1'b0;

      if (conflict && (cnt_base != CNT_MAX)) cnt_r <= cnt_base + CNT_W'(1);
      else                                   cnt_r <= cnt_base;

      if (any_en) begin
        state   <= KS_DRIVEN;
        bus_q_r <= value;
        valid_r <= 1'b1;
        idle_r  <= 1'b0;
      end else begin
        case (state)
          KS_DRIVEN: begin
            valid_r <= 1'b0;
            if (KEEP_CYCLES == 0) begin
              state   <= KS_IDLE;
              bus_q_r <= idle_val;
              idle_r  <= 1'b1;
            end else begin
              state    <= KS_HOLD;
              hold_cnt <= HOLD_LOAD;
              idle_r   <= 1'b0;
            end
          end
          KS_HOLD: begin
            if (hold_cnt == HW'(1)) begin
              state   <= KS_IDLE;
              bus_q_r <= idle_val;
              idle_r  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          default: begin
            // Idle level tracks the current mode.
            state   <= KS_IDLE;
            bus_q_r <= idle_val;
            valid_r <= 1'b0;
            idle_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.bus_q          = bus_q_r;
  assign bus.bus_valid      = valid_r;
  assign bus.idle           = idle_r;
  assign bus.contention     = cont_r;
  assign bus.err_sticky     = sticky_r;
  assign bus.contention_cnt = cnt_r;

endmodule
